// File: rtl/gm_pkg.sv
// Shared types and constants for the game-mode I/O arbiter.
// Used by the top level and by mode_switch_ctrl.
package gm_pkg;

  localparam logic [1:0] ST_ONGOING = 2'b00;
  localparam logic [1:0] ST_X_WIN   = 2'b01;
  localparam logic [1:0] ST_O_WIN   = 2'b10;
  localparam logic [1:0] ST_DRAW    = 2'b11;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_BLANK,
    S_ACTIVE
  } sw_state_t;

  function automatic logic [2:0] norm_mode(
    input logic [2:0] req,
    input logic [2:0] idle
  );
    return (req < idle) ? req : idle;
  endfunction

endpackage

// File: rtl/game_mode_io_arbiter_if.sv
// Board-side bundle of the game-mode arbiter: engine inputs,
// routed outputs and timer controls.
interface game_mode_io_arbiter_if #(
  parameter int NUM_MODES = 2,
  parameter int LED_W     = 9,
  parameter int GRID_W    = 18
);
  logic [2:0]                  mode_req;
  logic                        frame_begin;
  logic                        round_restart;
  logic [NUM_MODES*LED_W-1:0]  led_in;
  logic [NUM_MODES*4-1:0]      an_in;
  logic [NUM_MODES*8-1:0]      seg_in;
  logic [NUM_MODES*GRID_W-1:0] grid_in;
  logic [NUM_MODES*2-1:0]      status_in;

  logic [LED_W-1:0]            led;
  logic [3:0]                  an;
  logic [7:0]                  seg;
  logic [GRID_W-1:0]           grid_state;
  logic [1:0]                  status;
  logic [2:0]                  active_mode;
  logic                        switching;
  logic                        round_done;
  logic                        timer_hold;
  logic                        timer_reset;

  modport master (
    output mode_req, frame_begin, round_restart,
    output led_in, an_in, seg_in, grid_in, status_in,
    input  led, an, seg, grid_state, status,
    input  active_mode, switching,
    input  round_done, timer_hold, timer_reset
  );

  modport slave (
    input  mode_req, frame_begin, round_restart,
    input  led_in, an_in, seg_in, grid_in, status_in,
    output led, an, seg, grid_state, status,
    output active_mode, switching,
    output round_done, timer_hold, timer_reset
  );
endinterface

// File: rtl/game_mode_io_arbiter_mode_switch_ctrl.sv
// Mode switch FSM: target capture, frame-aligned commit, blanking.
// MODE_SWITCH_FRAME_SYNC_EN makes commits wait for frame_begin.
module mode_switch_ctrl
  import gm_pkg::*;
#(
  parameter int NUM_MODES    = 2,
  parameter int BLANK_FRAMES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] mode_req,
  input  logic       frame_begin,
  output sw_state_t  state,
  output logic [2:0] active_mode,
  output logic [2:0] target,
  output logic       commit
);

  localparam logic [2:0] IDLE_M = 3'(NUM_MODES);
  localparam logic [3:0] B_INIT = 4'(BLANK_FRAMES);

  sw_state_t  ret;
  logic [3:0] blank_cnt;
  logic [2:0] req_n;
  logic       fire;

  assign req_n = norm_mode(mode_req, IDLE_M);

`ifdef MODE_SWITCH_FRAME_SYNC_EN
  assign fire = frame_begin;
`else
  assign fire = 1'b1;
`endif

  assign commit = (state == S_WAIT_FRAME)
               && (req_n != active_mode)
               && fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ret         <= S_IDLE;
      active_mode <= IDLE_M;
      target      <= IDLE_M;
      blank_cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_ACTIVE: begin
          if (req_n != active_mode) begin
            target <= req_n;
            ret    <= state;
            state  <= S_WAIT_FRAME;
          end
        end
        S_WAIT_FRAME: begin
          // a request back to the live mode cancels the switch
          if (req_n == active_mode) begin
            state <= ret;
          end else if (fire) begin
            active_mode <= target;
            if (target == IDLE_M) begin
              blank_cnt <= '0;
              state     <= S_IDLE;
            end else if (BLANK_FRAMES == 0) begin
              state <= S_ACTIVE;
            end else begin
              blank_cnt <= B_INIT;
              state     <= S_BLANK;
            end
          end else begin
            target <= req_n;
          end
        end
        S_BLANK: begin
          if (req_n != active_mode) begin
            target <= req_n;
            ret    <= S_BLANK;
            state  <= S_WAIT_FRAME;
          end else if (frame_begin) begin
            blank_cnt <= blank_cnt - 4'd1;
            if (blank_cnt == 4'd1) state <= S_ACTIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/game_mode_io_arbiter.sv
// Routes the committed engine's I/O to the board; makes timer pulses.
// Optional macro: MODE_SWITCH_FRAME_SYNC_EN (frame-aligned commits).
module game_mode_io_arbiter
  import gm_pkg::*;
#(
  parameter int NUM_MODES    = 2,
  parameter int LED_W        = 9,
  parameter int GRID_W       = 18,
  parameter int BLANK_FRAMES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  game_mode_io_arbiter_if.slave io
);

  localparam logic [2:0] IDLE_M = 3'(NUM_MODES);

  sw_state_t         state;
  logic [2:0]        active_mode;
  logic [2:0]        target;
  logic              commit;
  logic              showing;
  logic              after_rst;
  logic [1:0]        prev_status;
  logic [LED_W-1:0]  sel_led;
  logic [3:0]        sel_an;
  logic [7:0]        sel_seg;
  logic [GRID_W-1:0] sel_grid;
  logic [1:0]        sel_status;
  logic [1:0]        tgt_status;

  mode_switch_ctrl #(
    .NUM_MODES    (NUM_MODES),
    .BLANK_FRAMES (BLANK_FRAMES)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .mode_req    (io.mode_req),
    .frame_begin (io.frame_begin),
    .state       (state),
    .active_mode (active_mode),
    .target      (target),
    .commit      (commit)
  );

  always_comb begin
    sel_led    = '0;
    sel_an     = AN_OFF;
    sel_seg    = SEG_OFF;
    sel_grid   = '0;
    sel_status = ST_ONGOING;
    tgt_status = ST_ONGOING;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (active_mode == 3'(i)) begin
        sel_led    = io.led_in[i*LED_W +: LED_W];
        sel_an     = io.an_in[i*4 +: 4];
        sel_seg    = io.seg_in[i*8 +: 8];
        sel_grid   = io.grid_in[i*GRID_W +: GRID_W];
        sel_status = io.status_in[i*2 +: 2];
      end
      if (target == 3'(i)) begin
        tgt_status = io.status_in[i*2 +: 2];
      end
    end
  end

  assign showing        = (state == S_ACTIVE);
  assign io.active_mode = active_mode;
  assign io.switching   = (state == S_WAIT_FRAME)
                       || (state == S_BLANK);

  always_ff @(posedge clk) begin
    if (reset) begin
      io.led         <= '0;
      io.an          <= AN_OFF;
      io.seg         <= SEG_OFF;
      io.grid_state  <= '0;
      io.status      <= ST_ONGOING;
      io.round_done  <= 1'b0;
      io.timer_hold  <= 1'b0;
      io.timer_reset <= 1'b0;
      prev_status    <= ST_ONGOING;
      after_rst      <= 1'b1;
    end else begin
      io.led        <= showing ? sel_led    : '0;
      io.an         <= showing ? sel_an     : AN_OFF;
      io.seg        <= showing ? sel_seg    : SEG_OFF;
      io.grid_state <= showing ? sel_grid   : '0;
      io.status     <= showing ? sel_status : ST_ONGOING;
      io.timer_hold <= showing && (sel_status != ST_ONGOING);
      io.round_done <= showing && (sel_status != prev_status);
      // reload on commit so a switch never looks like a result change
      prev_status   <= commit ? tgt_status : sel_status;
      io.timer_reset <= after_rst || io.round_restart
                     || (commit && (target != IDLE_M));
      after_rst     <= 1'b0;
    end
  end

endmodule

// File: doc/game_mode_io_arbiter.md
Name: game_mode_io_arbiter

Overview:
Parametrised successor to the board-level mode multiplexing. It selects one of NUM_MODES game engines (PvP, AI, future modes) and routes that engine's LEDs, 7-seg, grid state and game status to the board. Mode changes are tear-free: they commit only on an OLED frame boundary, followed by a programmable number of blanked frames. It also generates the round-done, timer-hold and timer-reset controls that the per-mode timers and scoreboards consume.

Parameters:
NUM_MODES, 2, number of engine channels (1..7)
LED_W, 9, LED bits per engine
GRID_W, 18, board state bits per engine (2 bits per cell)
BLANK_FRAMES, 1, frames forced to idle outputs after a switch commits (0..15)

Ports:
clk  in  1  system clock (100 MHz domain)
reset  in  1  synchronous, active-high
mode_req  in  3  requested mode; a value >= NUM_MODES means idle
frame_begin  in  1  one-cycle pulse at the start of each top-OLED frame (resynchronised upstream)
round_restart  in  1  one-cycle pulse; grid reset / general reset
led_in  in  NUM_MODES*LED_W  packed; engine i occupies slice [i*LED_W +: LED_W]
an_in  in  NUM_MODES*4  packed anode vectors
seg_in  in  NUM_MODES*8  packed segment vectors
grid_in  in  NUM_MODES*GRID_W  packed grid states
status_in  in  NUM_MODES*2  packed game status (00 ongoing, nonzero = result)
led  out  LED_W  routed LEDs
an  out  4  routed anodes
seg  out  8  routed segments
grid_state  out  GRID_W  routed grid
status  out  2  routed status
active_mode  out  3  committed mode; NUM_MODES = idle
switching  out  1  high during WAIT_FRAME and BLANK
round_done  out  1  one-cycle pulse
timer_hold  out  1  level
timer_reset  out  1  one-cycle pulse

Behaviour:
- FSM states: IDLE, WAIT_FRAME, BLANK, ACTIVE. Reset value is IDLE, with active_mode=NUM_MODES and the blank counter at 0.
- Idle output values: led=0, an=4'b1111, seg=8'hFF, grid_state=0, status=00. These drive in IDLE, WAIT_FRAME and BLANK, and are the reset values. round_done=0, timer_hold=0 and timer_reset=0 on reset.
- Normalised request: mode_req if < NUM_MODES, otherwise NUM_MODES.
- IDLE or ACTIVE:
  - If the normalised request differs from active_mode, store it as target and go to WAIT_FRAME.
- WAIT_FRAME:
  - On frame_begin, commit: active_mode <= target.
  - If the target is idle, go to IDLE.
  - Otherwise load the blank counter with BLANK_FRAMES and go to BLANK. If BLANK_FRAMES=0, go straight to ACTIVE.
  - If the request returns to the current active_mode before frame_begin, abort back to the previous state with no commit.
- BLANK:
  - Each frame_begin decrements the counter. Reaching 0 goes to ACTIVE.
  - If the normalised request differs from active_mode during BLANK, retarget and go to WAIT_FRAME.
- ACTIVE: all outputs are registered copies of the active_mode slice, with 1-cycle latency from the inputs.
- timer_hold: registered (status_in[active] != 00), only in ACTIVE; otherwise 0.
- round_done: pulses for one cycle when the selected status changes, in ACTIVE only. The previous-status register is reloaded on commit, so a switch never produces a spurious pulse.
- timer_reset: pulses for one cycle on any of the following:
  - the cycle after round_restart;
  - the cycle after a commit to a non-idle mode;
  - the cycle after reset deasserts.
  Coincident causes produce a single pulse.
- Reset asserted mid-switch returns to IDLE and discards the target.

Optional Feature:
MODE_SWITCH_FRAME_SYNC_EN
- Defined: commits wait for frame_begin, as described above.
- Undefined: WAIT_FRAME commits on the next clock edge without waiting. BLANK still counts frame_begin pulses.

Decomposition:
- Shared package gm_pkg holds:
  - status codes ST_ONGOING=2'b00, ST_X_WIN=2'b01, ST_O_WIN=2'b10, ST_DRAW=2'b11;
  - idle output constants AN_OFF=4'b1111 and SEG_OFF=8'hFF;
  - FSM state encodings.
- One sub-module, mode_switch_ctrl, holds the FSM, blank counter and active_mode. The top level does slice muxing and pulse generation.

Test Plan:
- Reset, then mode_req=0 with frame_begin every 100 cycles and BLANK_FRAMES=1:
  - outputs stay idle (an=1111) until the 2nd frame_begin;
  - then led=led_in[8:0] one cycle later;
  - timer_reset pulses once at commit.
- In ACTIVE mode 0, drive status_in[1:0] from 00 to 10: round_done pulses once and timer_hold goes 1. Drive it back to 00: round_done pulses and timer_hold goes 0.
- Active mode 0 with status=10, then request mode 1 whose status=00: no round_done; timer_hold=0 from BLANK onward.
- Request mode 1, then revert to 0 before frame_begin: no commit, active_mode stays 0, no timer_reset.
- mode_req=5 with NUM_MODES=2: transition to idle at next frame_begin, active_mode=2, seg=FF.
- round_restart coincident with commit: exactly one timer_reset pulse. Assert reset during BLANK: IDLE next cycle, outputs idle.
